// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control logic: forwarding
// select encodings, sequencing FSM states and the default halt code.
package mips_pkg;

  // Operand source selects driven to the EX-stage operand muxes
  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  // Sequencing FSM: normal execution or halted on a syscall
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  // v0 value that turns an EX-stage syscall into a halt request
  localparam logic [31:0] HALT_CODE_DEF = 32'd10;

endpackage

// File: rtl/fwd_unit.sv
// Forwarding compare for a single source operand. The youngest producer
// (MEM) wins over WB; register 0 is hard-wired and never forwards.
module fwd_unit
  import mips_pkg::*;
(
  input  logic [4:0] idx,
  input  logic [4:0] mem_dst,
  input  logic       mem_we,
  input  logic [4:0] wb_dst,
  input  logic       wb_we,
  output logic [1:0] sel
);

  // Priority compare: MEM first, then WB, else read the register file
  always_comb begin
    sel = FWD_RF;
    if (idx != 5'd0) begin
      if (mem_we && (mem_dst == idx)) begin
        sel = FWD_MEM;
      end else if (wb_we && (wb_dst == idx)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: operand forwarding, load-use stalls,
// taken-branch flushes, syscall halt FSM and display statistics.
module pipe_hazard_ctrl
  import mips_pkg::*;
#(
  parameter logic [31:0] HALT_CODE = HALT_CODE_DEF,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_r1_pos,
  input  logic [4:0]       id_r2_pos,
  input  logic             id_use_r1,
  input  logic             id_use_r2,
  input  logic [4:0]       ex_dst,
  input  logic             ex_we,
  input  logic             ex_mem_read,
  input  logic [4:0]       mem_dst,
  input  logic             mem_we,
  input  logic [4:0]       wb_dst,
  input  logic             wb_we,
  input  logic             ex_branch_taken,
  input  logic             ex_syscall,
  input  logic [31:0]      ex_v0,
  input  logic             go,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_flush,
  output logic             if_id_flush,
  output logic             pipe_freeze,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  state_t            state_reg, state_next;
  logic              resume_mask_reg, resume_mask_next;
  logic [CNT_W-1:0]  cycle_cnt_reg, stall_cnt_reg, flush_cnt_reg;

  logic [4:0]        src_idx [2];
  logic [1:0]        src_sel [2];

  logic              lu;
  logic              running;
  logic              branch_eff;
  logic              stall_eff;
  logic              halt_req;

  assign src_idx[0] = id_r1_pos;
  assign src_idx[1] = id_r2_pos;

  // One forwarding comparator per source operand (rs, rt)
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      fwd_unit u_fwd (
        .idx     (src_idx[gi]),
        .mem_dst (mem_dst),
        .mem_we  (mem_we),
        .wb_dst  (wb_dst),
        .wb_we   (wb_we),
        .sel     (src_sel[gi])
      );
    end
  endgenerate

  assign fwd_a = src_sel[0];
  assign fwd_b = src_sel[1];

  // Hazard qualification: a taken branch squashes the ID instruction, so
  // it cancels any load-use stall; the mask suppresses the still-present
  // syscall for the single cycle after a resume.
  always_comb begin
    lu = ex_mem_read && ex_we && (ex_dst != 5'd0) &&
         ((id_use_r1 && (ex_dst == id_r1_pos)) ||
          (id_use_r2 && (ex_dst == id_r2_pos)));
    running    = (state_reg == ST_RUN);
    branch_eff = running && ex_branch_taken;
    stall_eff  = running && lu && !ex_branch_taken;
    halt_req   = running && !resume_mask_reg && ex_syscall &&
                 (ex_v0 == HALT_CODE);
  end

  // FSM next state and pipeline control outputs
  always_comb begin
    state_next       = state_reg;
    resume_mask_next = 1'b0;
    pc_en            = 1'b1;
    if_id_en         = 1'b1;
    id_ex_flush      = 1'b0;
    if_id_flush      = 1'b0;
    pipe_freeze      = 1'b0;
    halted           = 1'b0;
    case (state_reg)
      ST_RUN: begin
        if (stall_eff) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end
        if (branch_eff) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end
        if (halt_req) begin
          pc_en      = 1'b0;
          if_id_en   = 1'b0;
          state_next = ST_HALT;
        end
      end
      ST_HALT: begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        pipe_freeze = 1'b1;
        halted      = 1'b1;
        if (go) begin
          state_next       = ST_RUN;
          resume_mask_next = 1'b1;
        end
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // State, resume mask and statistics counters (frozen while halted)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_RUN;
      resume_mask_reg <= 1'b0;
      cycle_cnt_reg   <= '0;
      stall_cnt_reg   <= '0;
      flush_cnt_reg   <= '0;
    end else begin
      state_reg       <= state_next;
      resume_mask_reg <= resume_mask_next;
      if (running) begin
        cycle_cnt_reg <= cycle_cnt_reg + CNT_W'(1);
      end
      if (stall_eff) begin
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      end
      if (branch_eff) begin
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign cycle_cnt = cycle_cnt_reg;
  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding priority, load-use
// stall, branch override, syscall halt/resume and reset from HALT.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  id_r1_pos, id_r2_pos;
  logic        id_use_r1, id_use_r2;
  logic [4:0]  ex_dst;
  logic        ex_we, ex_mem_read;
  logic [4:0]  mem_dst;
  logic        mem_we;
  logic [4:0]  wb_dst;
  logic        wb_we;
  logic        ex_branch_taken, ex_syscall;
  logic [31:0] ex_v0;
  logic        go;
  logic [1:0]  fwd_a, fwd_b;
  logic        pc_en, if_id_en, id_ex_flush, if_id_flush, pipe_freeze, halted;
  logic [31:0] cycle_cnt, stall_cnt, flush_cnt;

  int tests_run;
  int fail_cnt;
  int exp_cycle;

  pipe_hazard_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .id_r1_pos       (id_r1_pos),
    .id_r2_pos       (id_r2_pos),
    .id_use_r1       (id_use_r1),
    .id_use_r2       (id_use_r2),
    .ex_dst          (ex_dst),
    .ex_we           (ex_we),
    .ex_mem_read     (ex_mem_read),
    .mem_dst         (mem_dst),
    .mem_we          (mem_we),
    .wb_dst          (wb_dst),
    .wb_we           (wb_we),
    .ex_branch_taken (ex_branch_taken),
    .ex_syscall      (ex_syscall),
    .ex_v0           (ex_v0),
    .go              (go),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .id_ex_flush     (id_ex_flush),
    .if_id_flush     (if_id_flush),
    .pipe_freeze     (pipe_freeze),
    .halted          (halted),
    .cycle_cnt       (cycle_cnt),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // Advance one clock edge; inputs change and outputs are sampled 1ns later
  task automatic tick(input bit counts);
    @(posedge clk);
    #1;
    if (counts) exp_cycle++;
  endtask

  task automatic clear_inputs();
    id_r1_pos = 0; id_r2_pos = 0; id_use_r1 = 0; id_use_r2 = 0;
    ex_dst = 0; ex_we = 0; ex_mem_read = 0;
    mem_dst = 0; mem_we = 0; wb_dst = 0; wb_we = 0;
    ex_branch_taken = 0; ex_syscall = 0; ex_v0 = 0; go = 0;
  endtask

  initial begin
    tests_run = 0;
    fail_cnt  = 0;
    exp_cycle = 0;
    clear_inputs();
    rst = 1'b1;
    tick(0);
    tick(0);
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_fwd_a", 32'(fwd_a), 0);
    check("rst_fwd_b", 32'(fwd_b), 0);
    check("rst_pc_en", 32'(pc_en), 1);
    check("rst_if_id_en", 32'(if_id_en), 1);
    check("rst_id_ex_flush", 32'(id_ex_flush), 0);
    check("rst_if_id_flush", 32'(if_id_flush), 0);
    check("rst_freeze", 32'(pipe_freeze), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_cycle", cycle_cnt, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_flush", flush_cnt, 0);

    // Forwarding priority and register-0 exclusion
    mem_we = 1; mem_dst = 5; wb_we = 1; wb_dst = 5; id_r1_pos = 5; id_r2_pos = 5;
    #1;
    check("fwd_a_mem", 32'(fwd_a), 1);
    check("fwd_b_mem", 32'(fwd_b), 1);
    mem_we = 0;
    #1;
    check("fwd_a_wb", 32'(fwd_a), 2);
    mem_we = 1; mem_dst = 3;
    #1;
    check("fwd_b_wb_only", 32'(fwd_b), 2);
    mem_dst = 0; wb_dst = 0; id_r1_pos = 0;
    #1;
    check("fwd_a_r0", 32'(fwd_a), 0);
    mem_dst = 7; wb_we = 0; id_r2_pos = 9;
    #1;
    check("fwd_b_none", 32'(fwd_b), 0);
    clear_inputs();

    // Load-use stall on rt
    ex_mem_read = 1; ex_we = 1; ex_dst = 8; id_use_r2 = 1; id_r2_pos = 8;
    #1;
    check("lu_pc_en", 32'(pc_en), 0);
    check("lu_if_id_en", 32'(if_id_en), 0);
    check("lu_id_ex_flush", 32'(id_ex_flush), 1);
    check("lu_if_id_flush", 32'(if_id_flush), 0);
    tick(1);
    clear_inputs();
    #1;
    check("lu_stall_cnt", stall_cnt, 1);
    check("lu_after_pc_en", 32'(pc_en), 1);
    check("lu_after_flush", 32'(id_ex_flush), 0);

    // Load to r0 is never a hazard
    ex_mem_read = 1; ex_we = 1; ex_dst = 0; id_use_r1 = 1; id_r1_pos = 0;
    #1;
    check("lu_r0_pc_en", 32'(pc_en), 1);
    // rs match but rs not used: no hazard
    ex_dst = 4; id_r1_pos = 4; id_use_r1 = 0;
    #1;
    check("lu_unused_pc_en", 32'(pc_en), 1);
    clear_inputs();

    // Branch overrides load-use
    ex_mem_read = 1; ex_we = 1; ex_dst = 8; id_use_r2 = 1; id_r2_pos = 8;
    ex_branch_taken = 1;
    #1;
    check("br_if_id_flush", 32'(if_id_flush), 1);
    check("br_id_ex_flush", 32'(id_ex_flush), 1);
    check("br_pc_en", 32'(pc_en), 1);
    tick(1);
    clear_inputs();
    #1;
    check("br_stall_cnt", stall_cnt, 1);
    check("br_flush_cnt", flush_cnt, 1);

    // Syscall with a different v0 is ignored
    ex_syscall = 1; ex_v0 = 1;
    #1;
    check("sys1_pc_en", 32'(pc_en), 1);
    tick(1);
    check("sys1_halted", 32'(halted), 0);
    clear_inputs();

    // go in RUN does nothing
    go = 1;
    tick(1);
    go = 0;
    check("go_run_halted", 32'(halted), 0);

    // Halting syscall
    ex_syscall = 1; ex_v0 = 10;
    #1;
    check("sys10_pc_en", 32'(pc_en), 0);
    check("sys10_if_id_en", 32'(if_id_en), 0);
    check("sys10_halted_pre", 32'(halted), 0);
    tick(1);
    check("halt_halted", 32'(halted), 1);
    check("halt_freeze", 32'(pipe_freeze), 1);
    check("halt_pc_en", 32'(pc_en), 0);
    check("halt_cycle_a", cycle_cnt, 32'(exp_cycle));
    ex_branch_taken = 1;
    #1;
    check("halt_no_flush", 32'(if_id_flush), 0);
    for (int i = 0; i < 20; i++) tick(0);
    ex_branch_taken = 0;
    check("halt_cycle_hold", cycle_cnt, 32'(exp_cycle));
    check("halt_flush_hold", flush_cnt, 1);

    // Resume with syscall still in EX: masked for one cycle
    go = 1;
    tick(0);
    go = 0;
    check("resume_halted", 32'(halted), 0);
    check("resume_pc_en", 32'(pc_en), 1);
    tick(1);
    check("resume_no_rehalt", 32'(halted), 0);
    clear_inputs();

    // Run up to 36 cycles, halt on the 37th, then reset from HALT
    while (exp_cycle < 36) tick(1);
    ex_syscall = 1; ex_v0 = 10;
    tick(1);
    check("pre_rst_cycle", cycle_cnt, 37);
    check("pre_rst_halted", 32'(halted), 1);
    clear_inputs();
    rst = 1;
    tick(0);
    rst = 0;
    #1;
    check("rst_halt_halted", 32'(halted), 0);
    check("rst_halt_pc_en", 32'(pc_en), 1);
    check("rst_halt_cycle", cycle_cnt, 0);
    check("rst_halt_stall", stall_cnt, 0);
    check("rst_halt_flush", flush_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencing controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB), sitting beside the decode stage.
- Uses decode-stage source register indices and downstream destination/write-enable information to generate forwarding selects, load-use stalls and branch flushes.
- Runs the syscall halt FSM: halts when `v0 == 10`, resumes on `go`.
- Keeps cycle, stall and flush statistics counters for the board display.

Parameters:
- HALT_CODE, 32'd10, v0 value at an EX-stage syscall that halts the CPU
- CNT_W, 32, width of the statistics counters

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- id_r1_pos  in  5  rs index of instruction in ID
- id_r2_pos  in  5  rt index of instruction in ID
- id_use_r1  in  1  ID instruction reads rs
- id_use_r2  in  1  ID instruction reads rt
- ex_dst  in  5  destination of instruction in EX
- ex_we  in  1  EX instruction writes regfile
- ex_mem_read  in  1  EX instruction is a load
- mem_dst  in  5  destination in MEM
- mem_we  in  1  MEM instruction writes regfile
- wb_dst  in  5  destination in WB
- wb_we  in  1  WB instruction writes regfile
- ex_branch_taken  in  1  EX resolves taken branch/jump
- ex_syscall  in  1  syscall in EX
- ex_v0  in  32  forwarded v0 value for the EX syscall
- go  in  1  resume pulse (debounced externally)
- fwd_a  out  2  rs operand select: 0 regfile, 1 MEM, 2 WB
- fwd_b  out  2  rt operand select, same encoding
- pc_en  out  1  PC write enable
- if_id_en  out  1  IF/ID register enable
- id_ex_flush  out  1  insert bubble into ID/EX
- if_id_flush  out  1  clear IF/ID
- pipe_freeze  out  1  hold all pipeline registers (halt)
- halted  out  1  FSM in HALT
- cycle_cnt  out  CNT_W  cycles executed while not halted
- stall_cnt  out  CNT_W  load-use stall cycles
- flush_cnt  out  CNT_W  taken-branch flushes

Behaviour:
- Clock port `clk`, reset port `rst`; one clock; reset is synchronous and active-high.
- Reset: state RUN, all counters 0.
  - Combinational outputs take their default values: `fwd_a`/`fwd_b` 0, `pc_en`/`if_id_en` 1, flushes 0, `pipe_freeze` 0, `halted` 0.
- Forwarding (combinational, zero latency), evaluated for each operand:
  - Register index 0 never forwards.
  - MEM match (`mem_we && mem_dst == idx`) selects 1.
  - Else WB match selects 2.
  - Else 0.
  - MEM has priority over WB when both match.
- Load-use hazard (combinational): `lu = ex_mem_read && ex_we && ex_dst != 0 && ((id_use_r1 && ex_dst == id_r1_pos) || (id_use_r2 && ex_dst == id_r2_pos))`.
  - On `lu`: `pc_en = 0`, `if_id_en = 0`, `id_ex_flush = 1`.
  - Exactly one stall cycle per load-use pair.
- Taken branch in EX: `if_id_flush = 1` and `id_ex_flush = 1`; `pc_en` stays 1.
  - Branch overrides load-use: the ID instruction is squashed, so no stall is applied and `stall_cnt` does not increment.
- FSM states RUN and HALT:
  - RUN → HALT when `ex_syscall && ex_v0 == HALT_CODE` and not frozen. Takes effect at the next clock edge.
  - The syscall cycle itself behaves as RUN, but `pc_en` and `if_id_en` are forced to 0 so nothing younger advances past IF.
  - A syscall with any other `ex_v0` is a no-op for the FSM.
  - In HALT: `pipe_freeze = 1`, `pc_en = 0`, `if_id_en = 0`, flushes 0, `halted = 1`.
  - HALT → RUN on `go == 1`, sampled at the clock edge.
  - The frozen syscall still sits in EX on resume, so the FSM ignores `ex_syscall` for exactly one cycle after leaving HALT (one-cycle `resume_mask` register). This prevents re-halting on the same instruction.
- Counters:
  - `cycle_cnt` increments every cycle in RUN.
  - `stall_cnt` increments on cycles with an effective `lu` stall.
  - `flush_cnt` increments on `ex_branch_taken` in RUN.
  - All wrap modulo 2^CNT_W and do not change in HALT.
- `rst` asserted mid-stall or in HALT returns to RUN with counters cleared on that edge.
- `go` in RUN is ignored.

Decomposition:
- Shared package `mips_pkg`:
  - forwarding-select constants `FWD_RF = 0`, `FWD_MEM = 1`, `FWD_WB = 2`
  - state encoding `ST_RUN`, `ST_HALT`
  - `HALT_CODE` default
- One natural sub-module `fwd_unit`: pure combinational forwarding compare, instantiated twice (rs, rt).
- FSM, hazard logic and counters stay in the top.

Test Plan:
- `mem_we = 1, mem_dst = 5, wb_we = 1, wb_dst = 5, id_r1_pos = 5` → `fwd_a = 1`. With `mem_we = 0` → `fwd_a = 2`. With `id_r1_pos = 0` and both matching → `fwd_a = 0`.
- Load-use: `ex_mem_read = 1, ex_we = 1, ex_dst = 8, id_use_r2 = 1, id_r2_pos = 8` for 1 cycle → `pc_en = 0, if_id_en = 0, id_ex_flush = 1`, `stall_cnt` 0→1. Next cycle with EX cleared → `pc_en = 1`.
- Same load-use plus `ex_branch_taken = 1` → `if_id_flush = 1, id_ex_flush = 1, pc_en = 1`, `stall_cnt` unchanged, `flush_cnt` +1.
- `ex_syscall = 1, ex_v0 = 10` → next cycle `halted = 1, pipe_freeze = 1`; `cycle_cnt` holds for 20 cycles.
  - `go` pulse → RUN.
  - `ex_syscall` still 1 on the following cycle → no re-halt.
- `ex_syscall = 1, ex_v0 = 1` → stays in RUN, `halted = 0`.
- In HALT with `cycle_cnt = 37`, assert `rst` one cycle → RUN, all counters 0, `pc_en = 1`.
